score_display: RTL

Consumer of the 16-bit maze score: tracks the best (highest) finishing score and drives the board's 8-digit, active-low seven-segment display. It sits between the score timer's `score` / `won_the_game` outputs and the top-level `an` / `seg` / `dp` pins. Binary-to-BCD conversion is done with a sequential 16-iteration double-dabble engine rather than combinational dividers.

---
 rtl/score_display.sv | 126 ++++++++++++
 1 files changed

// File: rtl/score_display.sv
// score_display: best-score capture, double-dabble BCD conversion and 8-digit active-low display scan (optional SCORE_BLANK_ZEROS_EN blanks leading zeros)
module score_display #(
  parameter int CLK_FREQ = 100000000,
  parameter int SCAN_RATE = 1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] score,
  input  logic        won_the_game,
  input  logic        show_best,
  output logic [15:0] best,
  output logic        new_record,
  output logic [19:0] bcd_digits,
  output logic [7:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);
  localparam int SCAN_HIT = CLK_FREQ / SCAN_RATE - 1;
  localparam int CW = $clog2(SCAN_HIT + 1);
  localparam logic [CW-1:0] HIT = CW'(SCAN_HIT);
  typedef enum logic [1:0] {IDLE, SHIFT, LOAD} state_t;
  state_t state, state_nx;
  logic [CW-1:0] scan_cnt;
  logic scan_tick, won_prev, win_rec;
  logic [15:0] src;
  logic [19:0] bcd, bcd_adj, upper;
  logic [4:0] iter;
  logic [2:0] digit_idx, idx_nx;
  logic blank;
  logic [6:0] seg_nx;
  assign scan_tick = scan_cnt == HIT;
  assign win_rec = won_the_game & ~won_prev & (score > best);
  assign idx_nx = digit_idx + 1'b1;
  assign upper = bcd_digits >> {idx_nx, 2'b00};
`ifdef SCORE_BLANK_ZEROS_EN
  assign blank = idx_nx != 3'd0 && upper == 20'd0;
`else
  assign blank = idx_nx > 3'd4;
`endif
  // free-running scan divider, clears on the tick
  always_ff @(posedge clk)
    if (reset) scan_cnt <= '0;
    else scan_cnt <= scan_tick ? '0 : scan_cnt + 1'b1;
  // capture a strictly higher score on the rising edge of the win flag
  always_ff @(posedge clk)
    if (reset) begin
      won_prev <= 1'b0;
      best <= '0;
      new_record <= 1'b0;
    end else begin
      won_prev <= won_the_game;
      new_record <= win_rec;
      if (win_rec) best <= score;
    end
  // converter state register
  always_ff @(posedge clk) state <= reset ? IDLE : state_nx;
  // converter next state: one latch cycle, 16 shifts, one load
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = scan_tick ? SHIFT : IDLE;
      SHIFT:   state_nx = iter == 5'd15 ? LOAD : SHIFT;
      LOAD:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end
  // double-dabble correction: nibbles of 5 or more get +3 before the shift
  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < 5; i++)
      bcd_adj[4*i +: 4] = bcd[4*i +: 4] >= 4'd5 ? bcd[4*i +: 4] + 4'd3 : bcd[4*i +: 4];
  end
  // converter datapath; source is frozen at the start so input changes wait for the next run
  always_ff @(posedge clk)
    if (reset) begin
      src <= '0;
      bcd <= '0;
      iter <= '0;
      bcd_digits <= '0;
    end else begin
      case (state)
        IDLE: if (scan_tick) begin
          src <= show_best ? best : score;
          bcd <= '0;
          iter <= '0;
        end
        SHIFT: begin
          {bcd, src} <= {bcd_adj, src} << 1;
          iter <= iter + 1'b1;
        end
        LOAD: bcd_digits <= bcd;
        default: ;
      endcase
    end
  // active-low segment pattern for the digit about to be shown
  always_comb begin
    seg_nx = 7'h7F;
    if (!blank)
      case (upper[3:0])
        4'd0:    seg_nx = 7'h40;
        4'd1:    seg_nx = 7'h79;
        4'd2:    seg_nx = 7'h24;
        4'd3:    seg_nx = 7'h30;
        4'd4:    seg_nx = 7'h19;
        4'd5:    seg_nx = 7'h12;
        4'd6:    seg_nx = 7'h02;
        4'd7:    seg_nx = 7'h78;
        4'd8:    seg_nx = 7'h00;
        4'd9:    seg_nx = 7'h10;
        default: seg_nx = 7'h7F;
      endcase
  end
  // advance the scan and register the pins on each tick
  always_ff @(posedge clk)
    if (reset) begin
      digit_idx <= '0;
      an <= 8'hFF;
      seg <= 7'h7F;
      dp <= 1'b1;
    end else if (scan_tick) begin
      digit_idx <= idx_nx;
      an <= ~(8'b1 << idx_nx);
      seg <= seg_nx;
      dp <= ~(show_best && idx_nx == 3'd0);
    end
endmodule
